// File: rtl/jt12_pkg.sv
// Constants and FSM encoding shared by the per-slot pipeline taps.
package jt12_pkg;

  localparam int JT12_SLOTS     = 24;
  localparam int JT12_PEEK_TOUT = 2;

  localparam logic [1:0] PEEK_IDLE = 2'd0;
  localparam logic [1:0] PEEK_SEEK = 2'd1;
  localparam logic [1:0] PEEK_RESP = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = PEEK_IDLE,
    ST_SEEK = PEEK_SEEK,
    ST_RESP = PEEK_RESP
  } peek_state_e;

  // Number of clk_en cycles a read may wait before giving up.
  function automatic int peek_tout_limit(input int stages);
    return JT12_PEEK_TOUT * stages;
  endfunction

endpackage

// File: rtl/jt12_sh_peek_if.sv
// Request/response bus between a requester and the slot peek tap.
interface jt12_sh_peek_if #(
  parameter int width = 5,
  parameter int slotw = 5
);

  logic             req;
  logic [slotw-1:0] req_slot;
  logic             busy;
  logic             dout_valid;
  logic [width-1:0] dout;
  logic             err;

  modport master (
    output req, req_slot,
    input  busy, dout_valid, dout, err
  );

  modport slave (
    input  req, req_slot,
    output busy, dout_valid, dout, err
  );

endinterface

// File: rtl/jt12_slot_cnt.sv
// Tracks which slot sits at the output of a time-multiplexed shift line,
// aligning to sync and flagging syncs that arrive at an unexpected slot.
module jt12_slot_cnt
  import jt12_pkg::*;
#(
  parameter int stages = JT12_SLOTS,
  parameter int slotw  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             sync,
  output logic [slotw-1:0] slot_now,
  output logic             locked,
  output logic             sync_err
);

  localparam logic [slotw-1:0] LAST_SLOT = slotw'(stages - 1);

  logic [slotw-1:0] cnt_q, cnt_d;
  logic             locked_q, locked_d;
  logic             sync_err_q, sync_err_d;

  // sync forces slot 0 combinationally so a same-cycle match sees the realigned index.
  assign slot_now = sync ? '0 : cnt_q;

  // NOTE: every variable gets its default before any branch, so no latch is inferred.
  always_comb begin
    cnt_d      = cnt_q;
    locked_d   = locked_q;
    sync_err_d = 1'b0;
    if (clk_en) begin
      cnt_d = (slot_now == LAST_SLOT) ? '0 : slot_now + slotw'(1);
      if (sync) begin
        locked_d   = 1'b1;
        sync_err_d = locked_q && (cnt_q != '0);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      locked_q   <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      locked_q   <= locked_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign locked   = locked_q;
  assign sync_err = sync_err_q;

endmodule

// File: rtl/jt12_sh_peek.sv
// Read-side tap on a circulating per-slot shift line: captures one selected
// slot's value on request without disturbing the circulating data.
module jt12_sh_peek
  import jt12_pkg::*;
#(
  parameter int width  = 5,
  parameter int stages = JT12_SLOTS,
  parameter int slotw  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             sync,
  input  logic [width-1:0] din,
  jt12_sh_peek_if.slave    bus,
  output logic             locked,
  output logic             sync_err
);

  localparam int                TOUT_MAX  = peek_tout_limit(stages);
  localparam int                TOUT_W    = $clog2(TOUT_MAX + 1);
  localparam logic [TOUT_W-1:0] TOUT_LAST = TOUT_W'(TOUT_MAX - 1);
  localparam logic [slotw:0]    SLOT_LIM  = (slotw + 1)'(stages);

  peek_state_e       state_q, state_d;
  logic [slotw-1:0]  target_q, target_d;
  logic [TOUT_W-1:0] tout_q, tout_d;
  logic [width-1:0]  dout_q, dout_d;
  logic              err_q, err_d;

  logic [slotw-1:0]  slot_now;
  logic              hit;

  jt12_slot_cnt #(
    .stages (stages),
    .slotw  (slotw)
  ) u_slot_cnt (
    .clk      (clk),
    .rst      (rst),
    .clk_en   (clk_en),
    .sync     (sync),
    .slot_now (slot_now),
    .locked   (locked),
    .sync_err (sync_err)
  );

  // locked is the pre-edge value; a same-cycle sync also qualifies the match.
  assign hit = (locked || sync) && (slot_now == target_q);

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    tout_d   = tout_q;
    dout_d   = dout_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          if ({1'b0, bus.req_slot} >= SLOT_LIM) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            target_d = bus.req_slot;
            tout_d   = '0;
            state_d  = ST_SEEK;
          end
        end
      end
      ST_SEEK: begin
        if (clk_en) begin
          if (hit) begin
            dout_d  = din;
            err_d   = 1'b0;
            state_d = ST_RESP;
          end else if (tout_q == TOUT_LAST) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            tout_d = tout_q + TOUT_W'(1);
          end
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      target_q <= '0;
      tout_q   <= '0;
      dout_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      tout_q   <= tout_d;
      dout_q   <= dout_d;
      err_q    <= err_d;
    end
  end

  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.dout_valid = (state_q == ST_RESP);
  assign bus.dout       = dout_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_jt12_sh_peek.sv
// Scoreboard bench for jt12_sh_peek driven by a model of a 24-slot shift line.
module tb_jt12_sh_peek;
  import jt12_pkg::*;

  localparam int W  = 5;
  localparam int S  = 24;
  localparam int SW = 5;

  logic         clk    = 1'b0;
  logic         rst    = 1'b1;
  logic         clk_en = 1'b0;
  logic         sync   = 1'b0;
  logic [W-1:0] din    = '0;
  logic         locked;
  logic         sync_err;

  jt12_sh_peek_if #(.width(W), .slotw(SW)) bus ();

  jt12_sh_peek #(.width(W), .stages(S), .slotw(SW)) dut (
    .clk      (clk),
    .rst      (rst),
    .clk_en   (clk_en),
    .sync     (sync),
    .din      (din),
    .bus      (bus),
    .locked   (locked),
    .sync_err (sync_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] dout;
    logic         err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int vectors     = 0;
  int miscompares = 0;

  // Shift-line model: pos is the physical slot presented on din for the next edge.
  int pos       = 0;
  int en_div    = 1;
  int en_phase  = 0;
  bit sync_on   = 1'b0;
  bit inject_req = 1'b0;
  int last_edge_pos = 0;
  bit last_edge_en  = 1'b0;
  int en_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      last_edge_en  = clk_en;
      last_edge_pos = pos;
      if (clk_en) pos = (pos + 1) % S;
      #1;
      en_phase = (en_phase + 1) % en_div;
      clk_en   = (en_phase == 0);
      sync     = sync_on && (pos == 0);
      if (inject_req && clk_en && pos == 7) begin
        sync       = 1'b1;
        inject_req = 1'b0;
        sync_on    = 1'b0;
      end
      din = W'(pos + 8);
    end
  end

  always @(negedge clk) begin
    if (bus.dout_valid) begin
      check("valid_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("dout", bus.dout, mon_e.dout);
        check("err", bus.err, mon_e.err);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    bus.req = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_valid", bus.dout_valid, 0);
    check("rst_dout", bus.dout, 0);
    check("rst_err", bus.err, 0);
    check("rst_locked", locked, 0);
    check("rst_sync_err", sync_err, 0);
    rst = 1'b0;
  endtask

  task automatic wait_lock();
    int n = 0;
    while (!locked && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("lock", locked, 1);
  endtask

  task automatic do_req(input int slot, input logic [W-1:0] exp_dout, input logic exp_err);
    exp_t e;
    @(negedge clk);
    check("idle_busy", bus.busy, 0);
    check("idle_valid", bus.dout_valid, 0);
    bus.req      = 1'b1;
    bus.req_slot = SW'(slot);
    e.dout = exp_dout;
    e.err  = exp_err;
    exp_q.push_back(e);
    @(negedge clk);
    bus.req = 1'b0;
    if (slot < S) check("busy_after_accept", bus.busy, 1);
  endtask

  task automatic wait_resp(input string tag, input int limit);
    int n = 0;
    en_cnt = 0;
    while (!bus.dout_valid && n < limit) begin
      @(negedge clk);
      n++;
      if (last_edge_en) en_cnt++;
    end
    check(tag, bus.dout_valid, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.req      = 1'b0;
    bus.req_slot = '0;

    // Lock, then two back-to-back reads with clk_en every clock.
    sync_on = 1'b1;
    en_div  = 1;
    do_reset();
    wait_lock();
    do_req(5, 13, 1'b0);
    wait_resp("resp_slot5", 3 * S + 5);
    check("lat_slot5", 32'(en_cnt <= S), 1);
    do_req(6, 14, 1'b0);
    wait_resp("resp_slot6", 3 * S + 5);

    // Sparse enable: last slot, then slot 0 which coincides with sync.
    en_div = 3;
    do_req(23, 31, 1'b0);
    wait_resp("resp_slot23", 9 * S + 5);
    check("cap23_on_en", last_edge_en, 1);
    check("cap23_pos", last_edge_pos, 23);
    do_req(0, 8, 1'b0);
    wait_resp("resp_slot0", 9 * S + 5);
    check("cap0_on_en", last_edge_en, 1);
    check("cap0_pos", last_edge_pos, 0);

    // Out-of-range slot answers at once with err and keeps the previous dout.
    do_req(24, 8, 1'b1);
    check("bad_idx_valid", bus.dout_valid, 1);
    @(negedge clk);
    check("bad_busy_drop", bus.busy, 0);
    check("valid_one_clk", bus.dout_valid, 0);

    // No sync at all: the read times out after 2*stages enabled cycles.
    en_div  = 1;
    sync_on = 1'b0;
    do_reset();
    do_req(3, 0, 1'b1);
    wait_resp("resp_tout", 2 * S + 10);
    check("tout_en_cnt", en_cnt, 2 * S);
    check("tout_unlocked", locked, 0);

    // Misplaced sync at slot 7 renumbers the following slots from 0.
    sync_on = 1'b1;
    do_reset();
    wait_lock();
    inject_req = 1'b1;
    n = 0;
    while (!sync_err && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("sync_err_pulse", sync_err, 1);
    check("sync_err_pos", last_edge_pos, 7);
    check("lock_kept", locked, 1);
    @(negedge clk);
    check("sync_err_one_clk", sync_err, 0);
    do_req(2, 17, 1'b0);
    wait_resp("resp_realigned", 3 * S + 5);

    // Reset in the middle of a read, with a second request ignored while busy.
    sync_on = 1'b1;
    do_reset();
    wait_lock();
    @(negedge clk);
    check("abort_idle", bus.busy, 0);
    bus.req      = 1'b1;
    bus.req_slot = SW'((pos + 12) % S);
    @(negedge clk);
    check("abort_busy", bus.busy, 1);
    bus.req_slot = SW'((pos + 13) % S);
    @(negedge clk);
    bus.req = 1'b0;
    rst     = 1'b1;
    repeat (2) @(negedge clk);
    check("abort_busy_clr", bus.busy, 0);
    check("abort_no_valid", bus.dout_valid, 0);
    check("abort_unlocked", locked, 0);
    rst = 1'b0;
    wait_lock();
    repeat (5) @(negedge clk);
    do_req(10, 18, 1'b0);
    wait_resp("resp_after_abort", 3 * S + 5);

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
